// File: rtl/phy_tx_stripe.sv
// phy_tx_stripe: single-clock PHY transmitter that stripes NUM_LANES word lanes onto one
// serial bit stream in fixed round-robin slots.
//
// After reset it sends SYNC_WORDS slots of K_COM. It then cycles through lanes
// 0..NUM_LANES-1, one slot per lane. A slot carries the head of that lane's FIFO, or
// K_IDLE when the FIFO is empty. Bits are sent MSB first, one per clk_f cycle.
//
// Optional feature: define PHY_TX_PARITY_EN to append an even-parity bit after the LSB of
// every slot (COM and IDLE included), making a slot DATA_W+1 cycles long.
//
// Ports:
//   clk_f       clock; one serial bit per cycle
//   reset_L     asynchronous active-low reset; aborts the current word and empties all FIFOs
//   in_valid    per-lane word valid
//   in_data     lane i occupies bits [i*DATA_W +: DATA_W]
//   in_ready    per-lane FIFO not full (combinational from FIFO count)
//   data_out    serial bit, registered
//   word_start  high on the first bit of every slot
//   slot_lane   lane owning the current slot (0 during sync)
//   active      high once the sync preamble is complete
//   idle_out    high for every bit of an IDLE slot

module phy_tx_stripe #(
    parameter int unsigned       NUM_LANES  = 4,
    parameter int unsigned       DATA_W     = 8,
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter int unsigned       SYNC_WORDS = 4,
    parameter logic [DATA_W-1:0] K_COM      = 8'hBC,
    parameter logic [DATA_W-1:0] K_IDLE     = 8'h7C
) (
    input  logic                          clk_f,
    input  logic                          reset_L,
    input  logic [NUM_LANES-1:0]          in_valid,
    input  logic [NUM_LANES*DATA_W-1:0]   in_data,
    output logic [NUM_LANES-1:0]          in_ready,
    output logic                          data_out,
    output logic                          word_start,
    output logic [$clog2(NUM_LANES)-1:0]  slot_lane,
    output logic                          active,
    output logic                          idle_out
);

`ifdef PHY_TX_PARITY_EN
    localparam int unsigned SLOT_LEN = DATA_W + 1;
`else
    localparam int unsigned SLOT_LEN = DATA_W;
`endif
    localparam int unsigned LANE_W = $clog2(NUM_LANES);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned POS_W  = $clog2(SLOT_LEN);
    localparam int unsigned COM_W  = (SYNC_WORDS < 1) ? 1 : $clog2(SYNC_WORDS + 1);

    typedef enum logic [0:0] {StSync, StActive} state_e;

    // Builds the on-wire bit pattern of one slot from a word.
    function automatic logic [SLOT_LEN-1:0] frame(input logic [DATA_W-1:0] w);
`ifdef PHY_TX_PARITY_EN
        return {w, ^w};
`else
        return w;
`endif
    endfunction

    // ---------------------------------------------------------------- lane FIFOs
    logic [DATA_W-1:0] mem_q    [NUM_LANES][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [NUM_LANES];
    logic [PTR_W-1:0]  rd_ptr_q [NUM_LANES];
    logic [CNT_W-1:0]  cnt_q    [NUM_LANES];
    logic [NUM_LANES-1:0] push;
    logic [NUM_LANES-1:0] pop;

    always_comb begin
        in_ready = '0;
        push     = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            in_ready[i] = (cnt_q[i] < CNT_W'(FIFO_DEPTH));
            push[i]     = in_valid[i] & in_ready[i];
        end
    end

    always_ff @(posedge clk_f or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
                if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
                // pop is only ever raised on a non-empty FIFO, so no underflow here.
                if (push[i] && !pop[i]) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end else if (pop[i] && !push[i]) begin
                    cnt_q[i] <= cnt_q[i] - 1'b1;
                end
            end
        end
    end

    // Storage needs no reset: emptiness is tracked by the counts alone.
    always_ff @(posedge clk_f) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (push[i]) mem_q[i][wr_ptr_q[i]] <= in_data[i*DATA_W +: DATA_W];
        end
    end

    // ---------------------------------------------------------------- slot FSM
    state_e              state_q, state_d;
    logic                run_q, run_d;        // low until the first slot is loaded
    logic [POS_W-1:0]    pos_q, pos_d;        // index of the bit currently on data_out
    logic [COM_W-1:0]    com_q, com_d;        // COM slots already loaded
    logic [LANE_W-1:0]   lane_q, lane_d;      // lane of the next ACTIVE slot
    logic [SLOT_LEN-1:0] sh_q, sh_d;
    logic                ws_q, ws_d;
    logic [LANE_W-1:0]   slot_lane_q, slot_lane_d;
    logic                active_q, active_d;
    logic                idle_q, idle_d;
    logic                load;
    logic [DATA_W-1:0]   head;

    assign load = !run_q || (pos_q == POS_W'(SLOT_LEN - 1));
    assign head = mem_q[lane_q][rd_ptr_q[lane_q]];

    always_comb begin
        state_d     = state_q;
        run_d       = 1'b1;
        pos_d       = pos_q + 1'b1;
        com_d       = com_q;
        lane_d      = lane_q;
        sh_d        = sh_q << 1;
        ws_d        = 1'b0;
        slot_lane_d = slot_lane_q;
        active_d    = active_q;
        idle_d      = idle_q;
        pop         = '0;

        if (load) begin
            pos_d = '0;
            ws_d  = 1'b1;
            unique case (state_q)
                StSync: begin
                    if (com_q < COM_W'(SYNC_WORDS)) begin
                        com_d       = com_q + 1'b1;
                        sh_d        = frame(K_COM);
                        slot_lane_d = '0;
                        idle_d      = 1'b0;
                    end else begin
                        state_d = StActive;
                    end
                end
                StActive: ;
                default: ;
            endcase

            // First ACTIVE slot is loaded on the same edge the FSM leaves SYNC.
            if (state_d == StActive) begin
                active_d    = 1'b1;
                slot_lane_d = lane_q;
                lane_d      = (lane_q == LANE_W'(NUM_LANES - 1)) ? '0 : lane_q + 1'b1;
                if (cnt_q[lane_q] != '0) begin
                    pop[lane_q] = 1'b1;
                    sh_d        = frame(head);
                    idle_d      = 1'b0;
                end else begin
                    sh_d   = frame(K_IDLE);
                    idle_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_f or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= StSync;
            run_q       <= 1'b0;
            pos_q       <= '0;
            com_q       <= '0;
            lane_q      <= '0;
            sh_q        <= '0;
            ws_q        <= 1'b0;
            slot_lane_q <= '0;
            active_q    <= 1'b0;
            idle_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            pos_q       <= pos_d;
            com_q       <= com_d;
            lane_q      <= lane_d;
            sh_q        <= sh_d;
            ws_q        <= ws_d;
            slot_lane_q <= slot_lane_d;
            active_q    <= active_d;
            idle_q      <= idle_d;
        end
    end

    assign data_out   = sh_q[SLOT_LEN-1];
    assign word_start = ws_q;
    assign slot_lane  = slot_lane_q;
    assign active     = active_q;
    assign idle_out   = idle_q;

endmodule
